interrupt_request_collector: RTL and testbench

INTERRUPT_REQUEST_COLLECTOR -- requirements
Module: interrupt_request_collector

---
 rtl/interrupt_request_collector.sv | 84 ++++++++
 tb/tb_interrupt_request_collector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_request_collector.sv
// Interrupt request collector: synchronizes raw IRQ lines, detects events, and holds
// masked pending requests plus sticky overrun flags for a downstream arbiter.
module interrupt_request_collector #(
    parameter int unsigned BUS_WIDTH   = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 1,
    localparam int unsigned IDX_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1,
    localparam int unsigned CNT_W = $clog2(BUS_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] irq_in,
    input  logic [BUS_WIDTH-1:0] irq_mask,
    input  logic                 service_ack,
    input  logic [IDX_W-1:0]     service_idx,
    input  logic [BUS_WIDTH-1:0] overrun_clr,
    output logic [BUS_WIDTH-1:0] pending_bus,
    output logic                 pending_any,
    output logic [CNT_W-1:0]     pending_count,
    output logic [BUS_WIDTH-1:0] overrun
);

    logic [BUS_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [BUS_WIDTH-1:0] r_prev;
    logic [BUS_WIDTH-1:0] r_pending;
    logic [BUS_WIDTH-1:0] r_overrun;

    logic [BUS_WIDTH-1:0] w_sync;
    logic [BUS_WIDTH-1:0] w_event;
    logic [BUS_WIDTH-1:0] w_clr;
    logic [BUS_WIDTH-1:0] w_ovr_set;

    // Metastability chain followed by the history flop used for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= irq_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
        end
    end

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_event = ((EDGE_MODE != 0) ? (w_sync & ~r_prev) : w_sync) & irq_mask;

    // Out-of-range service indices decode to no clear at all
    always_comb begin
        w_clr = '0;
        if (service_ack && (32'(service_idx) < BUS_WIDTH)) begin
            w_clr[service_idx] = 1'b1;
        end
    end

    assign w_ovr_set = (EDGE_MODE != 0) ? (w_event & r_pending & ~w_clr) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_event;
            r_overrun <= (r_overrun & ~overrun_clr) | w_ovr_set;
        end
    end

    // Masking only hides a held request; pending_q keeps it
    assign pending_bus = r_pending & irq_mask;
    assign pending_any = |pending_bus;
    assign overrun     = r_overrun;

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < int'(BUS_WIDTH); i++) begin
            pending_count = pending_count + CNT_W'(pending_bus[i]);
        end
    end

endmodule

// File: tb/tb_interrupt_request_collector.sv
// Bench for interrupt_request_collector: directed scenarios plus random traffic,
// checked each cycle against a delay-line/behavioural model of the request rules.
module tb_interrupt_request_collector;

    localparam int W = 3;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] irq_in;
    logic [W-1:0] irq_mask;
    logic         service_ack;
    logic [1:0]   service_idx;
    logic [W-1:0] overrun_clr;
    logic [W-1:0] pending_bus;
    logic         pending_any;
    logic [1:0]   pending_count;
    logic [W-1:0] overrun;

    int n_checks = 0;
    int n_pass   = 0;
    logic cmp_en = 1'b0;

    interrupt_request_collector #(
        .BUS_WIDTH  (W),
        .SYNC_STAGES(S),
        .EDGE_MODE  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
        .irq_mask     (irq_mask),
        .service_ack  (service_ack),
        .service_idx  (service_idx),
        .overrun_clr  (overrun_clr),
        .pending_bus  (pending_bus),
        .pending_any  (pending_any),
        .pending_count(pending_count),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: m_hist[k] is the irq_in value sampled k+1 edges ago
    logic [W-1:0] m_pend = '0;
    logic [W-1:0] m_ovr  = '0;
    logic [W-1:0] m_hist [0:S] = '{default: '0};

    always @(posedge clk or negedge rst) begin : model
        if (!rst) begin
            m_pend <= '0;
            m_ovr  <= '0;
            for (int k = 0; k <= S; k++) m_hist[k] <= '0;
        end else begin : upd
            logic [W-1:0] np;
            logic [W-1:0] no;
            logic ev;
            logic clr;
            np = m_pend;
            no = m_ovr;
            for (int i = 0; i < W; i++) begin
                // line seen high now but low one sample earlier, and enabled
                ev  = m_hist[S-1][i] && !m_hist[S][i] && irq_mask[i];
                clr = service_ack && (int'(service_idx) == i);
                if (overrun_clr[i]) no[i] = 1'b0;
                if (ev) begin
                    if (m_pend[i] && !clr) no[i] = 1'b1;
                    np[i] = 1'b1;
                end else if (clr) begin
                    np[i] = 1'b0;
                end
            end
            m_pend <= np;
            m_ovr  <= no;
            for (int k = S; k > 0; k--) m_hist[k] <= m_hist[k-1];
            m_hist[0] <= irq_in;
        end
    end

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            chk("cyc_pending_bus", 32'(pending_bus), 32'(m_pend & irq_mask));
            chk("cyc_pending_any", 32'(pending_any), 32'(|(m_pend & irq_mask)));
            chk("cyc_pending_count", 32'(pending_count), 32'($countones(m_pend & irq_mask)));
            chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic ack(input logic [1:0] idx);
        service_ack = 1'b1;
        service_idx = idx;
        tick();
        service_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        irq_in = '0;
        irq_mask = 3'b111;
        service_ack = 1'b0;
        service_idx = '0;
        overrun_clr = '0;
        ticks(3);
        cmp_en = 1'b1;
        chk("reset_pending_bus", 32'(pending_bus), 32'h0);
        chk("reset_count", 32'(pending_count), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        rst = 1'b1;
        ticks(3);

        // single edge: visible on the third edge after sampling
        irq_in = 3'b010;
        ticks(2);
        chk("edge_not_yet", 32'(pending_bus), 32'h0);
        tick();
        chk("edge_latency", 32'(pending_bus), 32'h2);
        chk("edge_count", 32'(pending_count), 32'h1);
        ticks(5);
        chk("edge_held_once", 32'(pending_bus), 32'h2);
        chk("edge_no_overrun", 32'(overrun), 32'h0);

        // service
        irq_in = 3'b111;
        ticks(4);
        chk("svc_all_pending", 32'(pending_bus), 32'h7);
        ack(2'd2);
        chk("svc_idx2", 32'(pending_bus), 32'h3);
        chk("svc_idx2_count", 32'(pending_count), 32'h2);
        ack(2'd3);
        chk("svc_idx3_ignored", 32'(pending_bus), 32'h3);

        // overrun on line0
        for (int p = 0; p < 2; p++) begin
            irq_in = 3'b110;
            ticks(3);
            irq_in = 3'b111;
            ticks(4);
        end
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_pending_kept", 32'(pending_bus), 32'h3);
        overrun_clr = 3'b001;
        tick();
        overrun_clr = '0;
        chk("ovr_cleared", 32'(overrun), 32'h0);

        // set/clear collision on line1
        irq_in = 3'b101;
        ticks(3);
        irq_in = 3'b111;
        ticks(2);
        ack(2'd1);
        chk("coll_pending", 32'(pending_bus), 32'h3);
        chk("coll_no_overrun", 32'(overrun), 32'h0);

        for (int i = 0; i < W; i++) ack(2'(i));
        chk("all_cleared", 32'(pending_bus), 32'h0);

        // masking
        irq_mask = 3'b110;
        irq_in = 3'b110;
        ticks(3);
        irq_in = 3'b111;
        ticks(4);
        chk("mask_drop_pending", 32'(pending_bus), 32'h0);
        chk("mask_drop_overrun", 32'(overrun), 32'h0);
        irq_mask = 3'b111;
        #1;
        chk("mask_nothing_latched", 32'(pending_bus), 32'h0);
        irq_in = 3'b101;
        ticks(3);
        irq_in = 3'b111;
        ticks(4);
        chk("mask_line1_pending", 32'(pending_bus), 32'h2);
        irq_mask = 3'b101;
        #1;
        chk("mask_hides", 32'(pending_bus), 32'h0);
        irq_mask = 3'b111;
        #1;
        chk("mask_reappears", 32'(pending_bus), 32'h2);

        // reset mid-stream
        irq_in = 3'b010;
        ticks(3);
        irq_in = 3'b111;
        ticks(4);
        irq_in = 3'b101;
        ticks(3);
        irq_in = 3'b111;
        ticks(4);
        chk("pre_rst_pending", 32'(pending_bus), 32'h7);
        chk("pre_rst_overrun", 32'(overrun), 32'h2);
        rst = 1'b0;
        #1;
        chk("rst_async_pending", 32'(pending_bus), 32'h0);
        chk("rst_async_any", 32'(pending_any), 32'h0);
        chk("rst_async_count", 32'(pending_count), 32'h0);
        chk("rst_async_overrun", 32'(overrun), 32'h0);
        ticks(2);
        rst = 1'b1;
        ticks(2);
        chk("rel_not_yet", 32'(pending_bus), 32'h0);
        tick();
        chk("rel_one_event", 32'(pending_bus), 32'h7);
        chk("rel_count", 32'(pending_count), 32'h3);
        ticks(6);
        chk("rel_no_overrun", 32'(overrun), 32'h0);
        ack(2'd0);
        ticks(5);
        chk("rel_no_reset", 32'(pending_bus), 32'h6);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 3'($urandom);
            irq_mask    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
            service_ack = ($urandom_range(0, 2) == 0);
            service_idx = 2'($urandom_range(0, 3));
            overrun_clr = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
